node_nic_ctrl: RTL and testbench
================================

// Module: node_nic_ctrl
// PURPOSE
//  Network interface controller for one CMP node. It sits between the processor's
//  NIC register port (nicEn/nicWrEn/addr_nic/din_nic/dout_nic) and the ring router port.
//  It holds one input-channel packet buffer and one output-channel packet buffer.
//  It sequences router handshakes and exposes full/empty status to software polling.
// PARAMETERS
//  DATA_WIDTH   64   packet / register width in bits
// PORTS
//  clk        in   1           system clock, all state updates on rising edge
//  reset      in   1           synchronous, active-high reset
//  nicEn      in   1           processor access enable
//  nicWrEn    in   1           1 = write, 0 = read (qualified by nicEn)
//  addr_nic   in   2           register select: 00 in_buf, 01 in_status, 10 out_buf, 11 out_status
//  din_nic    in   DATA_WIDTH  processor write data
//  dout_nic   out  DATA_WIDTH  processor read data
//  net_si     in   1           router -> NIC packet valid (send-in)
//  net_ro     out  1           NIC -> router ready (input buffer empty)
//  net_di     in   DATA_WIDTH  router -> NIC packet
//  net_so     out  1           NIC -> router packet valid (output buffer full)
//  net_ri     in   1           router -> NIC ready
//  net_do     out  DATA_WIDTH  NIC -> router packet (= out_buf)
// BEHAVIOUR
//  Reset:
//   - State: in_full=0, out_full=0, in_buf=0, out_buf=0.
//   - net_ro is forced 0 while reset is high. dout_nic=0, net_so=0, net_do=0.
//  Input channel:
//   - net_ro = ~in_full & ~reset.
//   - At the edge with net_si & net_ro: in_buf<=net_di, in_full<=1.
//  Output channel:
//   - net_so = out_full; net_do = out_buf.
//   - At the edge with net_so & net_ri: out_full<=0. out_buf is retained, not cleared.
//  Processor reads (nicEn=1, nicWrEn=0):
//   - dout_nic is combinational, same cycle: 00 -> in_buf; 01 -> {63'b0,in_full};
//     10 -> out_buf; 11 -> {63'b0,out_full}.
//   - Read of 00 with in_full=1 clears in_full at the edge (packet consumed).
//   - Read of 00 with in_full=0 returns stale in_buf and has no side effect.
//  Processor writes (nicEn=1, nicWrEn=1):
//   - Write to 10 with out_full=0: out_buf<=din_nic, out_full<=1.
//   - Write to 10 with out_full=1: dropped. No state change, even if the router drains
//     in the same cycle; the decision uses the pre-edge out_full.
//   - Writes to 00/01/11 are ignored.
//  Idle outputs:
//   - dout_nic=0 whenever nicEn=0 or nicWrEn=1.
//  Simultaneous events:
//   - A router delivery and a processor consume of in_buf cannot coincide, because
//     net_ro is low while full.
//   - A consume edge makes net_ro=1 in the following cycle (1-cycle bubble).
//   - A processor write and a router drain in the same cycle follow the drop rule above.
//  Latency:
//   - Router delivery is visible on in_status from the next cycle.
//   - Processor write asserts net_so from the next cycle.
//  Reset mid-operation:
//   - Buffered packets are discarded. A handshake active in the reset cycle has no effect.
// TESTING
//  1. Reset, then read 01 and 11 -> 0. net_ro=0 during reset, 1 the cycle after release.
//  2. net_si=1, net_di=64'hDEAD_BEEF_0000_0001 -> net_ro=0 next cycle.
//     Read 01 -> 1. Read 00 -> same data. Next cycle read 01 -> 0 and net_ro=1.
//  3. Write 10 with 64'h0123_4567_89AB_CDEF, net_ri=0 -> net_so=1, net_do=that value.
//     Second write 64'h1 is dropped. net_ri=1 -> net_so=0 next cycle. Read 11 -> 0.
//  4. out_full=1, write 10 (64'h5) with net_ri=1 in the same cycle -> write dropped,
//     net_so=0 after the edge, out_buf still the old value.
//  5. in_full=1, assert reset for 1 cycle -> in_full=0, read 00 returns 0.
//     net_si held 1 during reset is not captured.
//  6. Read with nicEn=0 -> dout_nic=0. Writes to 00/01/11 -> no state change.

Source files
------------

// File: rtl/node_nic_ctrl.sv
// CMP node network interface: one input and one output packet buffer
// between the processor register port and the ring router port.
module node_nic_ctrl #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [1:0]            addr_nic,
    input  logic [DATA_WIDTH-1:0] din_nic,
    output logic [DATA_WIDTH-1:0] dout_nic,
    input  logic                  net_si,
    output logic                  net_ro,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ri,
    output logic [DATA_WIDTH-1:0] net_do
);

    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STAT = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STA = 2'b11;

    logic                  in_full;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;

    logic rd;
    logic wr;
    logic deliver;
    logic consume;
    logic drain;
    logic load;

    assign rd      = nicEn & ~nicWrEn;
    assign wr      = nicEn & nicWrEn;
    assign deliver = net_si & net_ro;
    assign consume = rd & (addr_nic == A_IN_BUF) & in_full;
    assign drain   = net_so & net_ri;
    // Drop decision uses the pre-edge out_full, so a same-cycle drain never admits a write.
    assign load    = wr & (addr_nic == A_OUT_BUF) & ~out_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_full  <= 1'b0;
            out_full <= 1'b0;
            in_buf   <= '0;
            out_buf  <= '0;
        end else begin
            if (deliver) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (consume) begin
                in_full <= 1'b0;
            end
            if (load) begin
                out_buf  <= din_nic;
                out_full <= 1'b1;
            end else if (drain) begin
                out_full <= 1'b0;
            end
        end
    end

    assign net_ro = ~in_full & ~reset;
    assign net_so = out_full & ~reset;
    assign net_do = reset ? '0 : out_buf;

    always_comb begin
        dout_nic = '0;
        if (rd && !reset) begin
            case (addr_nic)
                A_IN_BUF:  dout_nic = in_buf;
                A_IN_STAT: dout_nic = {{(DATA_WIDTH-1){1'b0}}, in_full};
                A_OUT_BUF: dout_nic = out_buf;
                A_OUT_STA: dout_nic = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:   dout_nic = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_node_nic_ctrl.sv
// Bench for node_nic_ctrl: queue-based model checked every cycle
// plus directed scenarios with literal expectations.
module tb_node_nic_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        nicEn;
    logic        nicWrEn;
    logic [1:0]  addr_nic;
    logic [63:0] din_nic;
    logic [63:0] dout_nic;
    logic        net_si;
    logic        net_ro;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ri;
    logic [63:0] net_do;

    int n_chk  = 0;
    int n_fail = 0;

    node_nic_ctrl #(.DATA_WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .nicEn    (nicEn),
        .nicWrEn  (nicWrEn),
        .addr_nic (addr_nic),
        .din_nic  (din_nic),
        .dout_nic (dout_nic),
        .net_si   (net_si),
        .net_ro   (net_ro),
        .net_di   (net_di),
        .net_so   (net_so),
        .net_ri   (net_ri),
        .net_do   (net_do)
    );

    always #5 clk = ~clk;

    // Model: each channel is a queue of at most one packet.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last  = '0;
    logic [63:0] out_last = '0;
    bit          started  = 0;

    always @(posedge clk) begin
        if (reset) begin
            in_q.delete();
            out_q.delete();
            in_last  = '0;
            out_last = '0;
            started  = 1;
        end else if (started) begin
            bit had_out;
            had_out = out_q.size() != 0;
            if (net_si && in_q.size() == 0) begin
                in_q.push_back(net_di);
                in_last = net_di;
            end else if (nicEn && !nicWrEn && addr_nic == 2'd0
                         && in_q.size() != 0) begin
                void'(in_q.pop_front());
            end
            if (had_out && net_ri)
                void'(out_q.pop_front());
            if (nicEn && nicWrEn && addr_nic == 2'd2 && !had_out) begin
                out_q.push_back(din_nic);
                out_last = din_nic;
            end
        end
    end

    function automatic logic [63:0] exp_dout();
        if (reset || !nicEn || nicWrEn) return '0;
        case (addr_nic)
            2'd0:    return in_last;
            2'd1:    return 64'(in_q.size());
            2'd2:    return out_last;
            default: return 64'(out_q.size());
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("m_net_ro", 64'(net_ro), 64'(!reset && in_q.size() == 0));
            check("m_net_so", 64'(net_so), 64'(!reset && out_q.size() != 0));
            check("m_net_do", net_do, reset ? 64'h0 : out_last);
            check("m_dout", dout_nic, exp_dout());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        nicEn   = 0;
        nicWrEn = 0;
        addr_nic = 0;
        din_nic = 0;
        net_si  = 0;
        net_di  = 0;
        net_ri  = 0;
    endtask

    // Combinational read poke, released before the next edge.
    task automatic rd_chk(input string name, input logic [1:0] a,
                          input logic [63:0] exp);
        nicEn    = 1;
        nicWrEn  = 0;
        addr_nic = a;
        #1;
        check(name, dout_nic, exp);
        nicEn = 0;
        #1;
    endtask

    task automatic wr_cyc(input logic [1:0] a, input logic [63:0] d);
        nicEn    = 1;
        nicWrEn  = 1;
        addr_nic = a;
        din_nic  = d;
        tick();
        nicEn   = 0;
        nicWrEn = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        settle();
        check("ro_in_reset", 64'(net_ro), 64'h0);
        tick();
        tick();
        reset = 0;
        settle();
        check("ro_after_rel", 64'(net_ro), 64'h1);
        rd_chk("rst_in_stat", 2'd1, 64'h0);
        rd_chk("rst_out_stat", 2'd3, 64'h0);
        rd_chk("rst_in_buf", 2'd0, 64'h0);

        // Router delivery, then processor consume with one-cycle bubble
        tick();
        net_si = 1;
        net_di = 64'hDEAD_BEEF_0000_0001;
        tick();
        net_si = 0;
        settle();
        check("ro_full", 64'(net_ro), 64'h0);
        rd_chk("in_stat_full", 2'd1, 64'h1);
        nicEn    = 1;
        addr_nic = 2'd0;
        #1;
        check("in_buf_data", dout_nic, 64'hDEAD_BEEF_0000_0001);
        tick();
        nicEn = 0;
        settle();
        rd_chk("in_stat_consumed", 2'd1, 64'h0);
        check("ro_bubble", 64'(net_ro), 64'h1);
        rd_chk("in_buf_stale", 2'd0, 64'hDEAD_BEEF_0000_0001);

        // Processor write, dropped second write, router drain
        wr_cyc(2'd2, 64'h0123_4567_89AB_CDEF);
        settle();
        check("so_after_wr", 64'(net_so), 64'h1);
        check("do_after_wr", net_do, 64'h0123_4567_89AB_CDEF);
        rd_chk("out_stat_full", 2'd3, 64'h1);
        tick();
        wr_cyc(2'd2, 64'h1);
        settle();
        check("do_drop", net_do, 64'h0123_4567_89AB_CDEF);
        tick();
        net_ri = 1;
        tick();
        net_ri = 0;
        settle();
        check("so_drained", 64'(net_so), 64'h0);
        rd_chk("out_stat_drained", 2'd3, 64'h0);
        check("do_retained", net_do, 64'h0123_4567_89AB_CDEF);

        // Write racing a drain is dropped
        tick();
        wr_cyc(2'd2, 64'hAA);
        net_ri = 1;
        wr_cyc(2'd2, 64'h5);
        net_ri = 0;
        settle();
        check("race_so", 64'(net_so), 64'h0);
        check("race_do", net_do, 64'hAA);
        rd_chk("race_out_buf", 2'd2, 64'hAA);

        // Reset discards buffered packet and ignores handshake
        tick();
        net_si = 1;
        net_di = 64'h77;
        tick();
        net_si = 0;
        settle();
        rd_chk("pre_rst_full", 2'd1, 64'h1);
        tick();
        reset  = 1;
        net_si = 1;
        net_di = 64'h99;
        settle();
        check("ro_mid_reset", 64'(net_ro), 64'h0);
        tick();
        reset  = 0;
        net_si = 0;
        settle();
        rd_chk("rst_cleared", 2'd1, 64'h0);
        rd_chk("rst_buf_zero", 2'd0, 64'h0);
        check("rst_ro", 64'(net_ro), 64'h1);

        // Idle outputs and ignored writes
        addr_nic = 2'd1;
        nicEn    = 0;
        #1;
        check("dout_no_en", dout_nic, 64'h0);
        tick();
        net_si = 1;
        net_di = 64'h42;
        tick();
        net_si = 0;
        nicEn    = 1;
        nicWrEn  = 1;
        addr_nic = 2'd0;
        #1;
        check("dout_on_write", dout_nic, 64'h0);
        wr_cyc(2'd0, 64'hF0);
        wr_cyc(2'd1, 64'h0);
        wr_cyc(2'd3, 64'h0);
        settle();
        rd_chk("ign_in_stat", 2'd1, 64'h1);
        rd_chk("ign_in_buf", 2'd0, 64'h42);
        rd_chk("ign_out_stat", 2'd3, 64'h0);
        check("ign_so", 64'(net_so), 64'h0);
        tick();
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
